// File: rtl/etpu_pkg.sv
// Shared constants and state encoding for the systolic-array sequencing logic.
package etpu_pkg;

  localparam int ARRAY_SIZE = 3;
  localparam int ROW_W      = 24;
  localparam int OUT_W      = 16;
  localparam int LANE_W     = ROW_W / ARRAY_SIZE;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_W = 3'd1,
    ST_STREAM = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_OUTPUT = 3'd4
  } state_e;

endpackage

// File: rtl/sysa_sched_skew.sv
// Enable-gated diagonal delay line: lane 1 is delayed one enabled cycle,
// lane 2 two enabled cycles. Lane 0 needs no storage and bypasses this block.
module sysa_skew
  import etpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic [LANE_W-1:0] lane1_in,
  input  logic [LANE_W-1:0] lane2_in,
  output logic [LANE_W-1:0] lane1_out,
  output logic [LANE_W-1:0] lane2_out
);

  logic [LANE_W-1:0] l1_q, l1_d;
  logic [LANE_W-1:0] l2a_q, l2a_d;
  logic [LANE_W-1:0] l2b_q, l2b_d;

  // Shift on enabled cycles only, flush on clear, otherwise hold.
  always_comb begin
    l1_d  = l1_q;
    l2a_d = l2a_q;
    l2b_d = l2b_q;
    if (clr) begin
      l1_d  = '0;
      l2a_d = '0;
      l2b_d = '0;
    end else if (en) begin
      l1_d  = lane1_in;
      l2a_d = lane2_in;
      l2b_d = l2a_q;
    end else begin
      l1_d  = l1_q;
      l2a_d = l2a_q;
      l2b_d = l2b_q;
    end
  end

  // Skew storage with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      l1_q  <= '0;
      l2a_q <= '0;
      l2b_q <= '0;
    end else begin
      l1_q  <= l1_d;
      l2a_q <= l2a_d;
      l2b_q <= l2b_d;
    end
  end

  assign lane1_out = l1_q;
  assign lane2_out = l2b_q;

endmodule

// File: rtl/sysa_sched.sv
// Job sequencer for the 3x3 systolic array: loads weights, streams skewed
// input rows, drains the pipeline, captures column outputs and returns them
// one row per beat.
module sysa_sched
  import etpu_pkg::*;
#(
  parameter int N_ROWS  = 3,
  parameter int ARR_LAT = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          abort,
  output logic                          busy,
  output logic                          done,
  input  logic                          wt_valid,
  input  logic [ROW_W-1:0]              wt_data,
  output logic                          wt_ready,
  input  logic                          in_valid,
  input  logic [ROW_W-1:0]              in_data,
  output logic                          in_ready,
  output logic                          sa_en,
  output logic [ARRAY_SIZE*ROW_W-1:0]   sa_w,
  output logic [ROW_W-1:0]              sa_in,
  input  logic [OUT_W-1:0]              sa_out1,
  input  logic [OUT_W-1:0]              sa_out2,
  input  logic [OUT_W-1:0]              sa_out3,
  output logic                          res_valid,
  output logic [ARRAY_SIZE*OUT_W-1:0]   res_data,
  output logic                          res_last,
  input  logic                          res_ready
);

  localparam int CNT_W = $clog2(N_ROWS + ARR_LAT + 5);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] ECNT_MAX   = '1;
  localparam logic [CNT_W-1:0] N_LAST     = CNT_W'(N_ROWS - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(ARR_LAT + 1);

  state_e                        state_q, state_d;
  logic [1:0]                    w_cnt_q, w_cnt_d;
  logic [CNT_W-1:0]              in_cnt_q, in_cnt_d;
  logic [CNT_W-1:0]              drain_cnt_q, drain_cnt_d;
  logic [CNT_W-1:0]              ecnt_q, ecnt_d;
  logic [CNT_W-1:0]              o_cnt_q, o_cnt_d;
  logic [ARRAY_SIZE*ROW_W-1:0]   sa_w_q, sa_w_d;
  logic [ARRAY_SIZE*OUT_W-1:0]   res_buf_q [N_ROWS];
  logic [ARRAY_SIZE*OUT_W-1:0]   res_buf_d [N_ROWS];
  logic                          done_q, done_d;

  logic                          wt_hs_s, in_hs_s, res_hs_s, en_s, kill_s;
  logic [LANE_W-1:0]             lane1_in_s, lane2_in_s, lane1_dly_s, lane2_dly_s;
  logic [OUT_W-1:0]              sa_out_s [ARRAY_SIZE];

  assign busy      = (state_q != ST_IDLE);
  assign wt_ready  = (state_q == ST_LOAD_W);
  assign in_ready  = (state_q == ST_STREAM);
  assign res_valid = (state_q == ST_OUTPUT);
  assign done      = done_q;
  assign sa_w      = sa_w_q;

  assign wt_hs_s  = wt_valid & wt_ready;
  assign in_hs_s  = in_valid & in_ready;
  assign res_hs_s = res_valid & res_ready;
  // The array only advances on accepted beats or while draining, so bubbles freeze it.
  assign en_s     = in_hs_s | (state_q == ST_DRAIN);
  assign sa_en    = en_s;
  assign kill_s   = abort & busy;

  assign sa_out_s[0] = sa_out1;
  assign sa_out_s[1] = sa_out2;
  assign sa_out_s[2] = sa_out3;

  // Drain pushes zeros into the delay line so it empties behind the last row.
  assign lane1_in_s = in_hs_s ? in_data[2*LANE_W-1:LANE_W]          : '0;
  assign lane2_in_s = in_hs_s ? in_data[3*LANE_W-1:2*LANE_W]        : '0;

  sysa_skew u_skew (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (kill_s),
    .en        (en_s),
    .lane1_in  (lane1_in_s),
    .lane2_in  (lane2_in_s),
    .lane1_out (lane1_dly_s),
    .lane2_out (lane2_dly_s)
  );

  // Lane mux: lane 0 direct, lanes 1/2 from the skew; last drain cycle forces zeros.
  always_comb begin
    sa_in = '0;
    if (state_q == ST_STREAM) begin
      sa_in = {lane2_dly_s, lane1_dly_s, (in_hs_s ? in_data[LANE_W-1:0] : {LANE_W{1'b0}})};
    end else if ((state_q == ST_DRAIN) && (drain_cnt_q != DRAIN_LAST)) begin
      sa_in = {lane2_dly_s, lane1_dly_s, {LANE_W{1'b0}}};
    end else begin
      sa_in = '0;
    end
  end

  // Result presentation: current buffered row while in OUTPUT, zero otherwise.
  always_comb begin
    res_data = '0;
    res_last = 1'b0;
    if (state_q == ST_OUTPUT) begin
      for (int r = 0; r < N_ROWS; r++) begin
        res_data = (o_cnt_q == CNT_W'(r)) ? res_buf_q[r] : res_data;
      end
      res_last = (o_cnt_q == N_LAST);
    end else begin
      res_data = '0;
      res_last = 1'b0;
    end
  end

  // Next-state, counters, weight load and result capture.
  always_comb begin
    state_d     = state_q;
    w_cnt_d     = w_cnt_q;
    in_cnt_d    = in_cnt_q;
    drain_cnt_d = drain_cnt_q;
    ecnt_d      = ecnt_q;
    o_cnt_d     = o_cnt_q;
    sa_w_d      = sa_w_q;
    res_buf_d   = res_buf_q;
    done_d      = 1'b0;

    // Column k of row r leaves the array ARR_LAT+k enabled cycles after row r's lane-0 beat.
    if (en_s) begin
      ecnt_d = (ecnt_q != ECNT_MAX) ? (ecnt_q + CNT_ONE) : ecnt_q;
      for (int r = 0; r < N_ROWS; r++) begin
        for (int k = 0; k < ARRAY_SIZE; k++) begin
          res_buf_d[r][k*OUT_W +: OUT_W] = (ecnt_q == CNT_W'(r + k + ARR_LAT)) ?
                                           sa_out_s[k] : res_buf_d[r][k*OUT_W +: OUT_W];
        end
      end
    end else begin
      ecnt_d = ecnt_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d     = ST_LOAD_W;
          w_cnt_d     = 2'd0;
          in_cnt_d    = '0;
          drain_cnt_d = '0;
          ecnt_d      = '0;
          o_cnt_d     = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD_W: begin
        if (wt_hs_s) begin
          for (int r = 0; r < ARRAY_SIZE; r++) begin
            sa_w_d[r*ROW_W +: ROW_W] = (w_cnt_q == 2'(r)) ? wt_data : sa_w_d[r*ROW_W +: ROW_W];
          end
          w_cnt_d = (w_cnt_q == 2'd2) ? 2'd0 : (w_cnt_q + 2'd1);
          state_d = (w_cnt_q == 2'd2) ? ST_STREAM : ST_LOAD_W;
        end else begin
          state_d = ST_LOAD_W;
        end
      end
      ST_STREAM: begin
        if (in_hs_s) begin
          in_cnt_d = in_cnt_q + CNT_ONE;
          state_d  = (in_cnt_q == N_LAST) ? ST_DRAIN : ST_STREAM;
        end else begin
          state_d = ST_STREAM;
        end
      end
      ST_DRAIN: begin
        drain_cnt_d = drain_cnt_q + CNT_ONE;
        state_d     = (drain_cnt_q == DRAIN_LAST) ? ST_OUTPUT : ST_DRAIN;
      end
      ST_OUTPUT: begin
        if (res_hs_s && (o_cnt_q == N_LAST)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else if (res_hs_s) begin
          o_cnt_d = o_cnt_q + CNT_ONE;
        end else begin
          state_d = ST_OUTPUT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort drops the job without a done pulse; loaded weights stay on the bus.
    if (kill_s) begin
      state_d     = ST_IDLE;
      w_cnt_d     = 2'd0;
      in_cnt_d    = '0;
      drain_cnt_d = '0;
      ecnt_d      = '0;
      o_cnt_d     = '0;
      done_d      = 1'b0;
      for (int r = 0; r < N_ROWS; r++) begin
        res_buf_d[r] = '0;
      end
    end else begin
      done_d = done_d;
    end
  end

  // State, counters, weights and result buffer with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      w_cnt_q     <= 2'd0;
      in_cnt_q    <= '0;
      drain_cnt_q <= '0;
      ecnt_q      <= '0;
      o_cnt_q     <= '0;
      sa_w_q      <= '0;
      done_q      <= 1'b0;
      for (int r = 0; r < N_ROWS; r++) begin
        res_buf_q[r] <= '0;
      end
    end else begin
      state_q     <= state_d;
      w_cnt_q     <= w_cnt_d;
      in_cnt_q    <= in_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      ecnt_q      <= ecnt_d;
      o_cnt_q     <= o_cnt_d;
      sa_w_q      <= sa_w_d;
      done_q      <= done_d;
      res_buf_q   <= res_buf_d;
    end
  end

endmodule

// File: tb/tb_sysa_sched.sv
// Scoreboard bench for sysa_sched with a behavioural stand-in for the array.
module tb_sysa_sched;

  localparam int N_ROWS  = 3;
  localparam int ARR_LAT = 3;

  logic        clk = 1'b0;
  logic        rst_n, start, abort, busy, done;
  logic        wt_valid, wt_ready, in_valid, in_ready, sa_en;
  logic        res_valid, res_last, res_ready;
  logic [23:0] wt_data, in_data, sa_in;
  logic [71:0] sa_w;
  logic [15:0] sa_out1, sa_out2, sa_out3;
  logic [47:0] res_data;

  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  int          rr_mode = 0;
  logic [48:0] exp_q [$];

  always #5 clk = ~clk;

  sysa_sched #(.N_ROWS(N_ROWS), .ARR_LAT(ARR_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .busy(busy), .done(done),
    .wt_valid(wt_valid), .wt_data(wt_data), .wt_ready(wt_ready),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .sa_en(sa_en), .sa_w(sa_w), .sa_in(sa_in),
    .sa_out1(sa_out1), .sa_out2(sa_out2), .sa_out3(sa_out3),
    .res_valid(res_valid), .res_data(res_data), .res_last(res_last), .res_ready(res_ready)
  );

  // Array stand-in: remembers lane data of the last enabled cycles.
  logic [23:0] hist [1:ARR_LAT+2] = '{default: 24'h0};
  logic [15:0] col_s [3];
  int          acc_s;

  // Shift lane history on every enabled cycle.
  always @(posedge clk) begin
    if (sa_en) begin
      hist[1] <= sa_in;
      for (int d = 2; d <= ARR_LAT + 2; d++) hist[d] <= hist[d-1];
    end
  end

  // Column k for a row is the dot product of its lanes (entered skewed) with weight column k.
  always_comb begin
    acc_s = 0;
    for (int k = 0; k < 3; k++) begin
      acc_s = 0;
      for (int j = 0; j < 3; j++)
        acc_s += int'($signed(hist[ARR_LAT+k-j][8*j +: 8])) * int'($signed(sa_w[24*j + 8*k +: 8]));
      col_s[k] = acc_s[15:0];
    end
  end

  assign sa_out1 = col_s[0];
  assign sa_out2 = col_s[1];
  assign sa_out3 = col_s[2];

  // Reference: y[k] = sum_j int8(x lane j) * int8(W[j][k]), truncated to 16 bits.
  function automatic logic [47:0] exp_row(input logic [23:0] w [3], input logic [23:0] xv);
    logic [47:0] r;
    int          s;
    r = '0;
    for (int k = 0; k < 3; k++) begin
      s = 0;
      for (int j = 0; j < 3; j++) s += int'($signed(xv[8*j +: 8])) * int'($signed(w[j][8*k +: 8]));
      r[16*k +: 16] = s[15:0];
    end
    return r;
  endfunction

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin errors++; $display("FAIL %s got=%0b exp=%0b", name, act, exp); end
  endtask

  task automatic checkw(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin errors++; $display("FAIL %s got=%0h exp=%0h", name, act, exp); end
  endtask

  task automatic checki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin errors++; $display("FAIL %s got=%0d exp=%0d", name, act, exp); end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Result consumer: always ready, random, or stalled.
  initial begin
    res_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rr_mode)
        0:       res_ready = 1'b1;
        1:       res_ready = 1'($urandom_range(0, 1));
        default: res_ready = 1'b0;
      endcase
    end
  end

  // Monitor: done pulses are counted, accepted result beats are matched against the queue.
  initial begin
    logic [48:0] e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
      if (res_valid === 1'b1 && res_ready === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_result got=%h last=%0b", res_data, res_last);
        end else begin
          e = exp_q.pop_front();
          if ({res_last, res_data} !== e) begin
            errors++;
            $display("FAIL result got last=%0b data=%h exp last=%0b data=%h",
                     res_last, res_data, e[48], e[47:0]);
          end
        end
      end
    end
  end

  task automatic check_reset_outputs();
    check1("rst_busy", busy, 1'b0);
    check1("rst_done", done, 1'b0);
    check1("rst_wt_ready", wt_ready, 1'b0);
    check1("rst_in_ready", in_ready, 1'b0);
    check1("rst_sa_en", sa_en, 1'b0);
    checkw("rst_sa_w", sa_w, 72'h0);
    checkw("rst_sa_in", 72'(sa_in), 72'h0);
    check1("rst_res_valid", res_valid, 1'b0);
    checkw("rst_res_data", 72'(res_data), 72'h0);
    check1("rst_res_last", res_last, 1'b0);
  endtask

  task automatic run_job(input logic [23:0] w [3], input logic [23:0] x [N_ROWS],
                         input bit bubble, input int abort_beat, input bit stray_start,
                         input bit stall, input bit rst_drain);
    int          n;
    int          dc0;
    bit          hs;
    logic [71:0] wpk;
    logic [47:0] held;
    wpk = {w[2], w[1], w[0]};
    if (abort_beat < 0 && !rst_drain)
      for (int r = 0; r < N_ROWS; r++) exp_q.push_back({(r == N_ROWS - 1), exp_row(w, x[r])});
    dc0 = done_cnt;
    if (stall) rr_mode = 2;
    start = 1'b1; tick(); start = 1'b0;
    check1("busy_after_start", busy, 1'b1);
    for (int i = 0; i < 3; i++) begin
      if ($urandom_range(0, 3) == 0) begin wt_valid = 1'b0; tick(); end
      wt_valid = 1'b1; wt_data = w[i];
      n = 0;
      do begin hs = wt_ready; tick(); n++; end while (!hs && n < 20);
      check1("wt_handshake", hs, 1'b1);
    end
    wt_valid = 1'b0;
    checkw("sa_w_loaded", sa_w, wpk);
    for (int b = 0; b < N_ROWS; b++) begin
      if (bubble && b > 0) begin
        in_valid = 1'b0;
        @(negedge clk); check1("sa_en_bubble", sa_en, 1'b0);
        tick();
      end
      in_valid = 1'b1; in_data = x[b];
      start = stray_start && (b == 1);
      abort = (b == abort_beat);
      n = 0;
      do begin
        @(negedge clk); hs = in_ready;
        if (hs) check1("sa_en_beat", sa_en, 1'b1);
        tick(); n++;
      end while (!hs && n < 20);
      check1("in_handshake", hs, 1'b1);
      start = 1'b0;
      if (abort) begin
        abort = 1'b0; in_valid = 1'b0;
        check1("busy_after_abort", busy, 1'b0);
        checkw("sa_w_kept_after_abort", sa_w, wpk);
        repeat (12) tick();
        checki("no_done_after_abort", done_cnt, dc0);
        return;
      end
    end
    in_valid = 1'b0;
    check1("stream_ends_after_n", in_ready, 1'b0);
    if (rst_drain) begin
      rst_n = 1'b0; tick(); rst_n = 1'b1;
      check_reset_outputs();
      repeat (12) tick();
      checki("no_done_after_reset", done_cnt, dc0);
      return;
    end
    if (stall) begin
      n = 0;
      while (!res_valid && n < 40) begin tick(); n++; end
      check1("stall_reached_output", res_valid, 1'b1);
      held = res_data;
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        check1("stall_valid_held", res_valid, 1'b1);
        checkw("stall_data_held", 72'(res_data), 72'(held));
        tick();
      end
      rr_mode = 0;
    end
    n = 0;
    while (done_cnt == dc0 && n < 300) begin tick(); n++; end
    repeat (3) tick();
    checki("done_once", done_cnt - dc0, 1);
    check1("idle_after_done", busy, 1'b0);
    checki("scoreboard_drained", exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog_timeout");
    $fatal(1);
  end

  initial begin
    logic [23:0] w [3];
    logic [23:0] x [N_ROWS];
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    wt_valid = 1'b0; wt_data = 24'h0; in_valid = 1'b0; in_data = 24'h0;
    repeat (2) tick();
    check_reset_outputs();
    rst_n = 1'b1; tick();

    // Identity weights: each result row reproduces its input row.
    w = '{24'h000001, 24'h000100, 24'h010000};
    x = '{24'h030201, 24'h060504, 24'h090807};
    run_job(w, x, 1'b0, -1, 1'b0, 1'b0, 1'b0);

    // All-2 weights, all-1 inputs: with bubbles and without.
    w = '{24'h020202, 24'h020202, 24'h020202};
    x = '{24'h010101, 24'h010101, 24'h010101};
    run_job(w, x, 1'b1, -1, 1'b0, 1'b0, 1'b0);
    run_job(w, x, 1'b0, -1, 1'b0, 1'b0, 1'b0);

    // Consumer stall in OUTPUT.
    for (int i = 0; i < 3; i++) w[i] = 24'($urandom);
    for (int i = 0; i < N_ROWS; i++) x[i] = 24'($urandom);
    run_job(w, x, 1'b0, -1, 1'b0, 1'b1, 1'b0);

    // Abort on the second beat, then a fresh job.
    run_job(w, x, 1'b0, 1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < N_ROWS; i++) x[i] = 24'($urandom);
    run_job(w, x, 1'b0, -1, 1'b0, 1'b0, 1'b0);

    // Stray start mid-stream, then reset during drain, then a fresh job.
    run_job(w, x, 1'b1, -1, 1'b1, 1'b0, 1'b0);
    run_job(w, x, 1'b0, -1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) w[i] = 24'($urandom);
    run_job(w, x, 1'b0, -1, 1'b0, 1'b0, 1'b0);

    // Signed extremes: 127 * -128 on every column.
    w = '{24'h00007F, 24'h007F00, 24'h7F0000};
    x = '{24'h808080, 24'h808080, 24'h808080};
    run_job(w, x, 1'b0, -1, 1'b0, 1'b0, 1'b0);

    // Random jobs with a random consumer and random bubbles.
    rr_mode = 1;
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 3; i++) w[i] = 24'($urandom);
      for (int i = 0; i < N_ROWS; i++) x[i] = 24'($urandom);
      run_job(w, x, 1'($urandom_range(0, 1)), -1, 1'b0, 1'b0, 1'b0);
    end
    rr_mode = 0;
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
